// File: rtl/snn_pkg.sv
// Shared definitions for the SNN front end: image geometry, loader and
// UART receiver state encodings, and the pixel address helper.
package snn_pkg;

   localparam int IMG_BITS   = 784;
   localparam int IMG_BYTES  = 98;
   localparam int ADDR_W     = 10;
   localparam int BYTE_CNT_W = 7;

   typedef enum logic [1:0] {
      ST_RECV,
      ST_WRITE,
      ST_START,
      ST_WAIT_CORE
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Pixel address 8k+i is just the byte index concatenated with the bit index.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [BYTE_CNT_W-1:0] byte_idx,
                                                     input logic [2:0]            bit_idx);
      return {byte_idx, bit_idx};
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit qualification at
// half a bit, mid-bit sampling of 8 data bits (LSB first) and the stop bit.
// A good stop bit yields a one-cycle byte_valid; a low stop bit sets the
// sticky frame_err and drops the byte.
module uart_rx
   import snn_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_meta_reg;
   logic             rx_sync_reg;
   logic             rx_prev_reg;
   logic             rx_fall;

   rx_state_t        state_reg,      state_next;
   logic [CNT_W-1:0] cnt_reg,        cnt_next;
   logic [2:0]       bit_reg,        bit_next;
   logic [7:0]       shift_reg,      shift_next;
   logic             valid_reg,      valid_next;
   logic             ferr_reg,       ferr_next;

   // Synchronize the asynchronous line and keep one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   assign rx_fall = rx_prev_reg & ~rx_sync_reg;

   // Receiver state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RX_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         valid_reg <= valid_next;
         ferr_reg  <= ferr_next;
      end
   end

   // Bit timing: count within the current bit and sample at its centre
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      valid_next = 1'b0;
      ferr_next  = ferr_reg;
      case (state_reg)
         RX_IDLE: begin
            cnt_next = '0;
            if (rx_fall) begin
               state_next = RX_START;
            end
         end
         RX_START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next = '0;
               bit_next = '0;
               // A line that is high again at mid start bit was only a glitch
               state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_reg == FULL_LAST) begin
               cnt_next   = '0;
               shift_next = {rx_sync_reg, shift_reg[7:1]};
               if (bit_reg == 3'd7) begin
                  state_next = RX_STOP;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (cnt_reg == FULL_LAST) begin
               cnt_next   = '0;
               state_next = RX_IDLE;
               if (rx_sync_reg) begin
                  valid_next = 1'b1;
               end else begin
                  ferr_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = RX_IDLE;
         end
      endcase
   end

   assign byte_valid = valid_reg;
   assign rx_byte    = shift_reg;
   assign frame_err  = ferr_reg;

endmodule

// File: rtl/image_loader.sv
// Loads a 784-pixel binary image, received as 98 UART bytes, into the
// input RAM of the SNN core one pixel per cycle, then pulses start and
// waits for the core's done before accepting the next image.
module image_loader
   import snn_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   input  logic              done,
   output logic              uart_data,
   output logic [ADDR_W-1:0] addr_input_unit,
   output logic              we,
   output logic              start,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam logic [BYTE_CNT_W-1:0] LAST_K = BYTE_CNT_W'(IMG_BYTES - 1);

   logic                  byte_valid;
   logic [7:0]            rx_byte;

   loader_state_t         state_reg,   state_next;
   logic [BYTE_CNT_W-1:0] k_reg,       k_next;
   logic [2:0]            i_reg,       i_next;
   logic [7:0]            hold_reg,    hold_next;
   logic [ADDR_W-1:0]     addr_reg,    addr_next;
   logic                  busy_reg,    busy_next;
   logic                  overrun_reg, overrun_next;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   // Loader state, byte/bit counters and the held copy of the last address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_RECV;
         k_reg       <= '0;
         i_reg       <= '0;
         hold_reg    <= '0;
         addr_reg    <= '0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         k_reg       <= k_next;
         i_reg       <= i_next;
         hold_reg    <= hold_next;
         addr_reg    <= addr_next;
         busy_reg    <= busy_next;
         overrun_reg <= overrun_next;
      end
   end

   // Next-state and outputs; RAM-side outputs are combinational so the first
   // pixel write lands in the cycle right after byte_valid.
   always_comb begin
      state_next      = state_reg;
      k_next          = k_reg;
      i_next          = i_reg;
      hold_next       = hold_reg;
      addr_next       = addr_reg;
      busy_next       = busy_reg;
      overrun_next    = overrun_reg;
      we              = 1'b0;
      start           = 1'b0;
      uart_data       = 1'b0;
      addr_input_unit = addr_reg;
      case (state_reg)
         ST_RECV: begin
            if (byte_valid) begin
               hold_next  = rx_byte;
               i_next     = '0;
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            we              = 1'b1;
            uart_data       = hold_reg[i_reg];
            addr_input_unit = pixel_addr(k_reg, i_reg);
            addr_next       = pixel_addr(k_reg, i_reg);
            busy_next       = 1'b1;
            if (i_reg == 3'd7) begin
               i_next = '0;
               if (k_reg == LAST_K) begin
                  k_next     = '0;
                  state_next = ST_START;
               end else begin
                  k_next     = k_reg + 1'b1;
                  state_next = ST_RECV;
               end
            end else begin
               i_next = i_reg + 3'd1;
            end
         end
         ST_START: begin
            start      = 1'b1;
            state_next = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            // The core still owns the RAM: bytes arriving now are lost
            if (byte_valid) begin
               overrun_next = 1'b1;
            end
            if (done) begin
               busy_next  = 1'b0;
               state_next = ST_RECV;
            end
         end
         default: begin
            state_next = ST_RECV;
         end
      endcase
      busy = busy_reg | (state_reg == ST_WRITE);
   end

   assign overrun = overrun_reg;

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: a UART byte driver, a RAM model that captures
// every write, and a reference image built from the bytes the receiver
// is expected to accept.
module tb_image_loader;

   localparam int CPB = 16;
   localparam int GAP = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic       done  = 1'b0;
   logic       uart_data;
   logic [9:0] addr_input_unit;
   logic       we;
   logic       start;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   image_loader #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx              (rx),
      .done            (done),
      .uart_data       (uart_data),
      .addr_input_unit (addr_input_unit),
      .we              (we),
      .start           (start),
      .busy            (busy),
      .frame_err       (frame_err),
      .overrun         (overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Observation state, owned by the monitor only
   logic ram [0:783];
   int   addr_q[$];
   int   wr_cnt      = 0;
   int   start_cnt   = 0;
   int   cyc         = 0;
   int   last_wr_cyc = -1;
   int   start_cyc   = -1;
   logic clr_req     = 1'b0;

   // Reference model, owned by the stimulus process
   logic       img_exp [0:783];
   int         k_model;
   logic [7:0] img_bytes [0:97];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_writes;
      logic       exp_ferr;
      int         exp_addr;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [0:7];
   int   n0;
   int   cnt_tmp;
   logic seen;

   // RAM model: captures writes and start pulses away from the active edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (clr_req) begin
         for (int j = 0; j < 784; j++) ram[j] <= 1'b0;
         addr_q.delete();
         wr_cnt      <= 0;
         start_cnt   <= 0;
         last_wr_cyc <= -1;
         start_cyc   <= -1;
      end else begin
         if (we) begin
            if (addr_input_unit < 10'd784) ram[addr_input_unit] <= uart_data;
            addr_q.push_back(int'(addr_input_unit));
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
         end
         if (start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_obs();
      clr_req = 1'b1;
      @(negedge clk);
      #1;
      clr_req = 1'b0;
   endtask

   task automatic clear_model();
      for (int j = 0; j < 784; j++) img_exp[j] = 1'b0;
      k_model = 0;
   endtask

   task automatic model_accept(input logic [7:0] b);
      for (int j = 0; j < 8; j++) img_exp[8 * k_model + j] = b[j];
      k_model++;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(CPB);
      for (int j = 0; j < 8; j++) begin
         rx = b[j];
         tick(CPB);
      end
      rx = stop_bit;
      tick(CPB);
      rx = 1'b1;
      tick(GAP);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      clear_obs();
      clear_model();
   endtask

   task automatic load_image();
      for (int b = 0; b < 98; b++) begin
         send_byte(img_bytes[b], 1'b1);
         model_accept(img_bytes[b]);
      end
      tick(30);
      #1;
   endtask

   task automatic check_image(input string tag);
      int mism;
      mism = 0;
      for (int j = 0; j < 784; j++) if (ram[j] !== img_exp[j]) mism++;
      check({tag, "_ram"}, 32'(mism), 0);
      mism = 0;
      foreach (addr_q[j]) if (addr_q[j] != j) mism++;
      check({tag, "_order"}, 32'(mism), 0);
      check({tag, "_writes"}, 32'(wr_cnt), 784);
      check({tag, "_start_cnt"}, 32'(start_cnt), 1);
      check({tag, "_start_lat"}, 32'(start_cyc - last_wr_cyc), 1);
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_start_low"}, 32'(start), 0);
      $display("image %s: writes=%0d starts=%0d busy=%0b", tag, wr_cnt, start_cnt, busy);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 8, 1'b0, 7,  1'b1};
      vecs[1] = '{8'h3C, 1'b1, 8, 1'b0, 15, 1'b1};
      vecs[2] = '{8'hFF, 1'b0, 0, 1'b1, 15, 1'b1};
      vecs[3] = '{8'h01, 1'b1, 8, 1'b1, 23, 1'b1};
      vecs[4] = '{8'h80, 1'b1, 8, 1'b1, 31, 1'b1};
      vecs[5] = '{8'h5A, 1'b1, 8, 1'b1, 39, 1'b1};
      vecs[6] = '{8'h00, 1'b0, 0, 1'b1, 39, 1'b1};
      vecs[7] = '{8'hC3, 1'b1, 8, 1'b1, 47, 1'b1};

      // Values held while reset is asserted
      tick(3);
      #1;
      check("rst_we", 32'(we), 0);
      check("rst_start", 32'(start), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_data", 32'(uart_data), 0);
      check("rst_addr", 32'(addr_input_unit), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_overrun", 32'(overrun), 0);
      rst_n = 1'b1;
      tick(2);
      clear_obs();
      clear_model();

      // Three-cycle low glitch must not start a frame
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(40);
      #1;
      check("glitch_writes", 32'(wr_cnt), 0);
      check("glitch_ferr", 32'(frame_err), 0);
      check("glitch_overrun", 32'(overrun), 0);
      check("glitch_busy", 32'(busy), 0);
      $display("glitch: writes=%0d ferr=%0b", wr_cnt, frame_err);

      // Table of single bytes, including bad stop bits
      for (int v = 0; v < 8; v++) begin
         n0 = wr_cnt;
         send_byte(vecs[v].data, vecs[v].stop);
         if (vecs[v].stop) model_accept(vecs[v].data);
         tick(12);
         #1;
         check("vec_writes", 32'(wr_cnt - n0), 32'(vecs[v].exp_writes));
         check("vec_ferr", 32'(frame_err), 32'(vecs[v].exp_ferr));
         check("vec_addr_hold", 32'(addr_input_unit), 32'(vecs[v].exp_addr));
         check("vec_busy", 32'(busy), 32'(vecs[v].exp_busy));
         check("vec_we_idle", 32'(we), 0);
         $display("vec %0d: byte=%02h stop=%0b writes=%0d addr=%0d", v, vecs[v].data,
                  vecs[v].stop, wr_cnt - n0, addr_input_unit);
      end
      cnt_tmp = 0;
      for (int j = 0; j < 784; j++) if (ram[j] !== img_exp[j]) cnt_tmp++;
      check("partial_ram", 32'(cnt_tmp), 0);
      cnt_tmp = 0;
      foreach (addr_q[j]) if (addr_q[j] != j) cnt_tmp++;
      check("partial_order", 32'(cnt_tmp), 0);
      check("partial_start", 32'(start_cnt), 0);

      // done outside WAIT_CORE is ignored
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(2);
      #1;
      check("done_ignored_busy", 32'(busy), 1);
      $display("done while receiving: busy=%0b", busy);

      // Full image of 0xA5
      do_reset();
      for (int b = 0; b < 98; b++) img_bytes[b] = 8'hA5;
      load_image();
      check_image("a5");
      check("a5_overrun", 32'(overrun), 0);

      // Byte arriving while the core runs is dropped and flagged
      n0 = wr_cnt;
      send_byte(8'h77, 1'b1);
      tick(12);
      #1;
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_writes", 32'(wr_cnt - n0), 0);
      check("ovr_busy", 32'(busy), 1);
      $display("overrun byte: overrun=%0b writes=%0d", overrun, wr_cnt - n0);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(2);
      #1;
      check("done_busy_low", 32'(busy), 0);
      $display("done pulse: busy=%0b", busy);

      // Second image without reset: single set pixel at address 0
      clear_obs();
      clear_model();
      img_bytes[0] = 8'h01;
      for (int b = 1; b < 98; b++) img_bytes[b] = 8'h00;
      load_image();
      check_image("one_px");
      cnt_tmp = 0;
      for (int j = 0; j < 784; j++) if (ram[j] === 1'b1) cnt_tmp++;
      check("one_px_ones", 32'(cnt_tmp), 1);
      check("one_px_addr0", 32'(ram[0]), 1);
      check("one_px_overrun_sticky", 32'(overrun), 1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(2);

      // Reset in the middle of writing byte 50
      do_reset();
      for (int b = 0; b < 98; b++) img_bytes[b] = 8'($urandom);
      for (int b = 0; b < 50; b++) send_byte(img_bytes[b], 1'b1);
      seen = 1'b0;
      fork
         send_byte(img_bytes[50], 1'b1);
         begin
            for (int n = 0; n < 400 && !seen; n++) begin
               @(negedge clk);
               if (we && addr_input_unit == 10'd403) begin
                  rst_n = 1'b0;
                  seen  = 1'b1;
               end
            end
         end
      join
      #1;
      check("mid_rst_seen", 32'(seen), 1);
      check("mid_rst_we", 32'(we), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_addr", 32'(addr_input_unit), 0);
      $display("reset during byte 50: seen=%0b we=%0b", seen, we);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      clear_obs();
      clear_model();
      for (int b = 0; b < 98; b++) img_bytes[b] = 8'($urandom);
      load_image();
      check_image("rand");
      check("rand_ferr", 32'(frame_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200 baud); legal minimum 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rx  input  1  UART serial line, idle high, 8N1, asynchronous to clk.
REQ-005 done  input  1  single-cycle pulse from snn_core: classification finished.
REQ-006 uart_data  output  1  pixel bit written to ram_input_unit.
REQ-007 addr_input_unit  output  10  pixel write address, 0..783.
REQ-008 we  output  1  ram_input_unit write enable.
REQ-009 start  output  1  single-cycle pulse to snn_core: image loaded.
REQ-010 busy  output  1  high from first pixel write until done is received.
REQ-011 frame_err  output  1  sticky: stop bit sampled low.
REQ-012 overrun  output  1  sticky: byte received while in WAIT_CORE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver: falling edge on synced rx starts a frame; re-sample at CLKS_PER_BIT/2; if high, abort frame, return to idle.
REQ-015 Data bits sampled at mid-bit every CLKS_PER_BIT cycles, LSB first, 8 bits.
REQ-016 Stop bit sampled mid-bit; high -> 1-cycle byte_valid with byte; low -> set frame_err, drop byte, no byte_valid.
REQ-017 Loader states: RECV, WRITE, START, WAIT_CORE; reset to RECV.
REQ-018 RECV: on byte_valid latch byte into holding register -> WRITE; byte counter k (0..97) unchanged.
REQ-019 WRITE: 8 consecutive cycles, we=1, addr_input_unit=8k+i, uart_data=byte[i], i=0..7.
REQ-020 After bit 7: if k==97 -> START and k:=0, else k:=k+1 -> RECV.
REQ-021 START: start=1 exactly one cycle, we=0 -> WAIT_CORE.
REQ-022 WAIT_CORE: done -> RECV; byte_valid here sets overrun and byte dropped, no writes.
REQ-023 we=0 in every state except WRITE; addr_input_unit holds last value outside WRITE.
REQ-024 busy=1 from first WRITE cycle of byte 0 until the cycle after done; 0 otherwise.
REQ-025 done outside WAIT_CORE ignored.
REQ-026 Image fill latency: last pixel write 1..8 cycles after byte 97 byte_valid; start the following cycle.
REQ-027 frame_err and overrun cleared only by reset.
REQ-028 Partial image (<98 bytes) held indefinitely; no timeout.

Reset
REQ-029 rst_n low SHALL immediately force: state RECV, k=0, i=0, receiver idle, we=0, start=0, busy=0, uart_data=0, addr_input_unit=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-030 Reset mid-WRITE or mid-frame abandons the image; next image restarts at addr 0.

Structure
REQ-031 Shared package snn_pkg: loader state enum, IMG_BITS=784, IMG_BYTES=98, ADDR_W=10.
REQ-032 One sub-module uart_rx (synchronizer, bit timing, byte_valid/byte/frame_err), parameterised by CLKS_PER_BIT; loader FSM in image_loader.

Verification
REQ-033 CLKS_PER_BIT=16; send 98 bytes 0xA5 -> 784 writes, addr 0..783 in order, data pattern 1,0,1,0,0,1,0,1 per byte; start one pulse; busy high.
REQ-034 Send 0x01 then 97x 0x00 -> only addr 0 written 1; RAM readback matches 784-bit image.
REQ-035 Frame with stop bit 0 at byte 5 -> frame_err=1, no writes, next good byte written at addr 40..47.
REQ-036 Glitch low 3 cycles on rx -> no byte_valid, no writes, no flags.
REQ-037 Full image, then 1 byte before done -> overrun=1, no writes; pulse done -> busy=0, next image starts addr 0.
REQ-038 rst_n low during WRITE of byte 50 -> we=0 immediately; after release full image loads from addr 0, start after byte 97.
